// File: rtl/pe_col_drain_if.sv
// Output stream of a PE column drain: data word, capture row, last flag and
// a valid/ready handshake.
interface pe_col_drain_if #(
  parameter int OUT_WIDTH = 32,
  parameter int ROW_W     = 3
);
  logic [OUT_WIDTH-1:0] out_data;
  logic [ROW_W-1:0]     out_row;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, out_row, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_row, out_last, out_valid, output out_ready);
endinterface

// File: rtl/pe_col_drain.sv
// Drains one systolic PE column into a FIFO and streams it out over valid/ready.
// Define PE_DRAIN_SAT_EN to saturate psums to OUT_WIDTH instead of truncating.
module pe_col_drain #(
  parameter int ROWS       = 8,
  parameter int IN_WIDTH   = 48,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                drain_start_in,
  input  logic                col_valid_in,
  input  logic [IN_WIDTH-1:0] bottom_in,
  pe_col_drain_if.master      out_if,
  output logic                busy,
  output logic                overflow_err
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = OUT_WIDTH + ROW_W + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

  logic [1:0]           state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   head;
  logic [OUT_WIDTH-1:0] conv_data;
  logic                 full, pop, wr_attempt, wr_accept;

`ifdef PE_DRAIN_SAT_EN
  // The value fits in OUT_WIDTH only if every bit above the new sign bit copies it.
  logic [IN_WIDTH-OUT_WIDTH:0] hi_bits;
  always_comb begin
    hi_bits = bottom_in[IN_WIDTH-1:OUT_WIDTH-1];
    if (hi_bits == '0 || hi_bits == '1)
      conv_data = bottom_in[OUT_WIDTH-1:0];
    else if (bottom_in[IN_WIDTH-1])
      conv_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      conv_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^bottom_in[IN_WIDTH-1:OUT_WIDTH];
  assign conv_data = bottom_in[OUT_WIDTH-1:0];
`endif

  assign full = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = valid_q && out_if.out_ready;
  assign wr_attempt = (state_q == CAPTURE) && col_valid_in;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign wr_accept  = wr_attempt && (!full || pop);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)       rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_attempt && !wr_accept) ovf_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (drain_start_in) begin
          state_d = CAPTURE;
          row_d   = '0;
        end
      end
      CAPTURE: begin
        if (col_valid_in) begin
          row_d = row_q + ROW_W'(1);
          if (row_q == LAST_ROW) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (wr_ptr_d == rd_ptr_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (wr_ptr_d != rd_ptr_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {conv_data, row_q, (row_q == LAST_ROW)};
  end

  assign head = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Outputs are forced to zero while empty so reset leaves a clean bus.
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = valid_q ? head[ENTRY_W-1 -: OUT_WIDTH] : '0;
  assign out_if.out_row   = valid_q ? head[ROW_W:1] : '0;
  assign out_if.out_last  = valid_q && head[0];
  assign busy             = (state_q != IDLE);
  assign overflow_err     = ovf_q;

endmodule

// File: tb/tb_pe_col_drain.sv
// Directed bench for pe_col_drain: an 8-row column and a 20-row column sharing
// a 16-deep FIFO configuration; popped words are logged and checked per test.
module tb_pe_col_drain;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [47:0] bottom_in;
  logic        start8, valid8, start20, valid20;
  logic        busy8, ovf8, busy20, ovf20;
  int          tests_run = 0;
  int          tests_failed = 0;

  logic [37:0] mon8[$];
  logic [37:0] mon20[$];

  pe_col_drain_if #(.OUT_WIDTH(32), .ROW_W(3)) if8 ();
  pe_col_drain_if #(.OUT_WIDTH(32), .ROW_W(5)) if20 ();

  pe_col_drain #(.ROWS(8), .IN_WIDTH(48), .OUT_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .drain_start_in(start8), .col_valid_in(valid8),
    .bottom_in(bottom_in), .out_if(if8.master), .busy(busy8), .overflow_err(ovf8));

  pe_col_drain #(.ROWS(20), .IN_WIDTH(48), .OUT_WIDTH(32), .FIFO_DEPTH(16)) dut_ovf (
    .clk(clk), .rst(rst), .drain_start_in(start20), .col_valid_in(valid20),
    .bottom_in(bottom_in), .out_if(if20.master), .busy(busy20), .overflow_err(ovf20));

  // Log every word that is handed over, sampled mid-cycle before the popping edge.
  always @(negedge clk) begin
    if (if8.out_valid && if8.out_ready)
      mon8.push_back({if8.out_data, 5'(if8.out_row), if8.out_last});
    if (if20.out_valid && if20.out_ready)
      mon20.push_back({if20.out_data, 5'(if20.out_row), if20.out_last});
  end

  logic [47:0] sat_in [8] = '{48'h0000_8000_0000, 48'hFFFF_FFFF_FFFB, 48'h8000_0000_0000,
                              48'h0000_7FFF_FFFF, 48'hFFFF_8000_0000, 48'hFFFF_7FFF_FFFF,
                              48'h0, 48'd42};
`ifdef PE_DRAIN_SAT_EN
  logic [31:0] sat_exp [8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'h0, 32'd42};
`else
  logic [31:0] sat_exp [8] = '{32'h8000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'd42};
`endif

  function automatic logic [37:0] pk(input logic [31:0] d, input int r, input logic l);
    return {d, 5'(r), l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start8 = 0; valid8 = 0; start20 = 0; valid20 = 0; bottom_in = '0;
    if8.out_ready = 0; if20.out_ready = 0;
    tick(); tick();
    rst = 1'b0;
    mon8.delete();
    mon20.delete();
  endtask

  task automatic test_reset();
    logic [36:0] got8, got20;
    rst = 1'b1;
    start8 = 0; valid8 = 0; start20 = 0; valid20 = 0; bottom_in = '0;
    if8.out_ready = 0; if20.out_ready = 0;
    tick(); tick();
    got8  = {if8.out_valid, if8.out_data, if8.out_last, busy8, ovf8};
    got20 = {if20.out_valid, if20.out_data, if20.out_last, busy20, ovf20};
    tests_run++;
    if (got8 !== 37'h0 || if8.out_row !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_dut8: got %h row %0d, expected all zero", got8, if8.out_row);
    end
    tests_run++;
    if (got20 !== 37'h0 || if20.out_row !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_dut20: got %h row %0d, expected all zero", got20, if20.out_row);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [37:0] got;
    do_reset();
    if8.out_ready = 1;
    start8 = 1; tick(); start8 = 0;
    tests_run++;
    if (busy8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy_start: got %b expected 1", busy8);
    end
    for (int i = 1; i <= 8; i++) begin
      valid8 = 1; bottom_in = 48'(i); tick();
      if (i == 1) begin
        tests_run++;
        if (if8.out_valid !== 1'b1 || if8.out_data !== 32'd1) begin
          tests_failed++;
          $display("FAIL basic_first_visible: valid %b data %h expected 1/1",
                   if8.out_valid, if8.out_data);
        end
      end
    end
    valid8 = 0;
    tests_run++;
    if ({busy8, if8.out_valid, if8.out_last} !== 3'b111) begin
      tests_failed++;
      $display("FAIL basic_flush_last: busy/valid/last %b expected 111",
               {busy8, if8.out_valid, if8.out_last});
    end
    tick();
    tests_run++;
    if (busy8 !== 1'b0 || if8.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_busy_end: busy %b valid %b expected 0/0", busy8, if8.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      got = (mon8.size() > i) ? mon8[i] : 'x;
      tests_run++;
      if (got !== pk(32'(i + 1), i, i == 7)) begin
        tests_failed++;
        $display("FAIL basic_word%0d: got %h expected %h", i, got, pk(32'(i + 1), i, i == 7));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [37:0] got;
    do_reset();
    start8 = 1; tick(); start8 = 0;
    for (int i = 0; i < 8; i++) begin
      valid8 = 1; bottom_in = 48'h0_A5A5_0000 + 48'(i); tick();
    end
    valid8 = 0;
    for (int k = 0; k < 11; k++) tick();
    tests_run++;
    if ({if8.out_valid, mon8.size() == 0, ovf8} !== 3'b110) begin
      tests_failed++;
      $display("FAIL bp_hold: valid/none_popped/ovf %b expected 110",
               {if8.out_valid, mon8.size() == 0, ovf8});
    end
    if8.out_ready = 1;
    for (int k = 0; k < 30 && busy8; k++) tick();
    tests_run++;
    if (busy8 !== 1'b0 || ovf8 !== 1'b0 || mon8.size() != 8) begin
      tests_failed++;
      $display("FAIL bp_done: busy %b ovf %b count %0d expected 0/0/8", busy8, ovf8, mon8.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (mon8.size() > i) ? mon8[i] : 'x;
      tests_run++;
      if (got !== pk(32'hA5A5_0000 + 32'(i), i, i == 7)) begin
        tests_failed++;
        $display("FAIL bp_word%0d: got %h expected %h", i, got, pk(32'hA5A5_0000 + 32'(i), i, i == 7));
      end
    end
  endtask

  task automatic test_overflow();
    logic [37:0] got;
    do_reset();
    start20 = 1; tick(); start20 = 0;
    for (int i = 1; i <= 20; i++) begin
      valid20 = 1; bottom_in = 48'(i); tick();
      if (i == 16) begin
        tests_run++;
        if (ovf20 !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_before_drop: got %b expected 0", ovf20);
        end
      end
      if (i == 17) begin
        tests_run++;
        if (ovf20 !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovf_first_drop: got %b expected 1", ovf20);
        end
      end
    end
    valid20 = 0;
    tests_run++;
    if ({busy20, if20.out_valid} !== 2'b11) begin
      tests_failed++;
      $display("FAIL ovf_flush_hold: busy/valid %b expected 11", {busy20, if20.out_valid});
    end
    if20.out_ready = 1;
    for (int k = 0; k < 40 && busy20; k++) tick();
    tests_run++;
    if (busy20 !== 1'b0 || ovf20 !== 1'b1 || mon20.size() != 16) begin
      tests_failed++;
      $display("FAIL ovf_done: busy %b ovf %b count %0d expected 0/1/16", busy20, ovf20, mon20.size());
    end
    for (int i = 0; i < 16; i++) begin
      got = (mon20.size() > i) ? mon20[i] : 'x;
      tests_run++;
      if (got !== pk(32'(i + 1), i, 1'b0)) begin
        tests_failed++;
        $display("FAIL ovf_word%0d: got %h expected %h", i, got, pk(32'(i + 1), i, 1'b0));
      end
    end
  endtask

  task automatic test_saturation();
    logic [37:0] got;
    do_reset();
    if8.out_ready = 1;
    start8 = 1; tick(); start8 = 0;
    for (int i = 0; i < 8; i++) begin
      valid8 = 1; bottom_in = sat_in[i]; tick();
    end
    valid8 = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      got = (mon8.size() > i) ? mon8[i] : 'x;
      tests_run++;
      if (got !== pk(sat_exp[i], i, i == 7)) begin
        tests_failed++;
        $display("FAIL sat_word%0d: in %h got %h expected %h", i, sat_in[i], got, pk(sat_exp[i], i, i == 7));
      end
    end
  endtask

  task automatic test_reset_and_start();
    logic [37:0] got;
    do_reset();
    start8 = 1; tick(); start8 = 0;
    for (int i = 0; i < 3; i++) begin
      valid8 = 1; bottom_in = 48'h200 + 48'(i); tick();
    end
    valid8 = 0;
    rst = 1; tick(); rst = 0;
    tests_run++;
    if ({if8.out_valid, busy8} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_mid_drain: valid/busy %b expected 00", {if8.out_valid, busy8});
    end
    valid8 = 1; bottom_in = 48'd99; tick(); tick();
    valid8 = 0;
    tests_run++;
    if ({if8.out_valid, busy8} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_ignores_valid: valid/busy %b expected 00", {if8.out_valid, busy8});
    end
    mon8.delete();
    if8.out_ready = 1;
    start8 = 1; tick(); start8 = 0;
    for (int i = 0; i < 8; i++) begin
      valid8 = 1; start8 = (i == 4); bottom_in = 48'h300 + 48'(i); tick();
    end
    valid8 = 0; start8 = 0;
    tick();
    tests_run++;
    if (busy8 !== 1'b0 || mon8.size() != 8) begin
      tests_failed++;
      $display("FAIL restart_done: busy %b count %0d expected 0/8", busy8, mon8.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (mon8.size() > i) ? mon8[i] : 'x;
      tests_run++;
      if (got !== pk(32'h300 + 32'(i), i, i == 7)) begin
        tests_failed++;
        $display("FAIL restart_word%0d: got %h expected %h", i, got, pk(32'h300 + 32'(i), i, i == 7));
      end
    end
  endtask

  task automatic test_full_pop();
    logic [37:0] got;
    do_reset();
    start20 = 1; tick(); start20 = 0;
    for (int i = 1; i <= 20; i++) begin
      valid20 = 1; bottom_in = 48'(i);
      if (i == 17) if20.out_ready = 1;
      tick();
      if (i == 17) begin
        tests_run++;
        if (ovf20 !== 1'b0 || if20.out_data !== 32'd2) begin
          tests_failed++;
          $display("FAIL fullpop_write: ovf %b head %h expected 0/2", ovf20, if20.out_data);
        end
      end
    end
    valid20 = 0;
    for (int k = 0; k < 40 && busy20; k++) tick();
    tests_run++;
    if (busy20 !== 1'b0 || ovf20 !== 1'b0 || mon20.size() != 20) begin
      tests_failed++;
      $display("FAIL fullpop_done: busy %b ovf %b count %0d expected 0/0/20", busy20, ovf20, mon20.size());
    end
    for (int i = 0; i < 20; i++) begin
      got = (mon20.size() > i) ? mon20[i] : 'x;
      tests_run++;
      if (got !== pk(32'(i + 1), i, i == 19)) begin
        tests_failed++;
        $display("FAIL fullpop_word%0d: got %h expected %h", i, got, pk(32'(i + 1), i, i == 19));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_reset_and_start();
    test_full_pop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pe_col_drain.md
PE_COL_DRAIN -- requirements
Module: pe_col_drain

Interface
REQ-001 SHALL have parameter ROWS, default 8: PE rows per column, which is the number of words per drain.
REQ-002 SHALL have parameter IN_WIDTH, default 48: width of the partial sum arriving from the bottom PE.
REQ-003 SHALL have parameter OUT_WIDTH, default 32: width of the output stream word.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: power of two, at least 2.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port drain_start_in, input, 1: one-cycle pulse that arms a column drain.
REQ-008 SHALL have port col_valid_in, input, 1: bottom_in carries a drained psum this cycle.
REQ-009 SHALL have port bottom_in, input, IN_WIDTH: the bottom_out of the lowest PE in the column.
REQ-010 SHALL have port out_data, output, OUT_WIDTH: stream data.
REQ-011 SHALL have port out_row, output, $clog2(ROWS): capture index of out_data, 0 for the first captured word.
REQ-012 SHALL have port out_last, output, 1: marks the ROWS-th word of a drain.
REQ-013 SHALL have port out_valid, output, 1 and port out_ready, input, 1: valid/ready handshake.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have port overflow_err, output, 1: sticky flag for a dropped word.

Function
REQ-016 SHALL implement FSM states IDLE, CAPTURE and FLUSH.
REQ-017 SHALL move IDLE->CAPTURE on drain_start_in, with the row counter set to 0; in IDLE, col_valid_in SHALL be ignored.
REQ-018 SHALL, in CAPTURE, write one entry per col_valid_in cycle: {converted bottom_in, row counter, last = (counter == ROWS-1)}, then increment the counter.
REQ-019 SHALL move CAPTURE->FLUSH on the write attempt whose counter equals ROWS-1; the counter SHALL advance even if the word is dropped.
REQ-020 SHALL move FLUSH->IDLE on the cycle the FIFO becomes empty; drain_start_in outside IDLE SHALL be ignored.
REQ-021 SHALL present the FIFO head on out_data/out_row/out_last while out_valid = not empty; a pop SHALL occur when out_valid && out_ready.
REQ-022 SHALL accept a write when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-023 SHALL, on a write refused by a full FIFO, drop the word and set overflow_err until rst; the array cannot be back-pressured.
REQ-024 SHALL make a word written at edge t visible with out_valid=1 after edge t, with out_valid registered and no combinational path from bottom_in to out_*.
REQ-025 SHALL, on a simultaneous pop and write when the FIFO is empty, leave the FIFO holding one entry.
REQ-026 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and distinguish full from empty with an extra pointer bit.

Reset
REQ-027 SHALL, on rst, set state IDLE, counter 0, FIFO empty, out_valid 0, out_data 0, out_row 0, out_last 0, busy 0 and overflow_err 0.
REQ-028 SHALL, on rst asserted mid-drain, abort the drain, discard FIFO contents and lower out_valid on the next cycle.

Configuration
REQ-029 SHALL, with PE_DRAIN_SAT_EN defined, saturate signed bottom_in to OUT_WIDTH: above 2^(OUT_WIDTH-1)-1 gives 0x7FFFFFFF, below -2^(OUT_WIDTH-1) gives 0x80000000.
REQ-030 SHALL, without PE_DRAIN_SAT_EN, take bottom_in[OUT_WIDTH-1:0] by plain truncation.

Verification
REQ-031 SHALL cover the basic drain: start, then 8 valid cycles with psums 1..8, out_ready=1 -> out_data 1..8, out_row 0..7, out_last only on 8, busy falls after the last pop.
REQ-032 SHALL cover backpressure: out_ready=0 for 20 cycles during the drain of 8 -> no loss, overflow_err=0, order preserved after release.
REQ-033 SHALL cover overflow: ROWS=20, FIFO_DEPTH=16, out_ready=0 -> 16 words kept, words 16..19 dropped, overflow_err=1, FSM reaches FLUSH.
REQ-034 SHALL cover saturation: bottom_in=48'h0000_8000_0000 -> 0x7FFFFFFF with PE_DRAIN_SAT_EN and 0x80000000 without; bottom_in=-5 -> 0xFFFFFFFB in both builds.
REQ-035 SHALL cover reset and start edge cases: rst after 3 of 8 words -> out_valid=0 next cycle, busy=0, and a fresh drain starts at out_row 0; drain_start_in during CAPTURE -> ignored.
REQ-036 SHALL cover full-FIFO write with pop: FIFO full, out_ready=1 and col_valid_in=1 together -> write accepted, overflow_err stays 0.
